mem_arbiter: RTL
================

# mem_arbiter

Two-port memory arbiter that lets the instruction cache and the data cache share one slow-memory port. It sits between the two `cache` instances and the single off-chip memory interface. Each cache keeps its existing memory-side handshake unchanged. The arbiter grants one transaction at a time with round-robin tie-breaking. It registers the granted request onto the memory bus and steers `mem_ready`/`mem_rdata` back to the owner.

## Interface
Parameters:
- ADDR_W, 28, block address width (address bits [31:4])
- DATA_W, 128, block data width

Ports. Clock and reset: one clock, `clk`; reset `proc_reset` is asynchronous and active-high.
- clk  input  1  system clock, all state on rising edge
- proc_reset  input  1  asynchronous active-high reset
- i_read  input  1  I-cache memory read request, held until i_ready
- i_write  input  1  I-cache memory write request, held until i_ready
- i_addr  input  ADDR_W  I-cache block address
- i_wdata  input  DATA_W  I-cache write block
- i_rdata  output  DATA_W  read block to I-cache, valid only while i_ready=1
- i_ready  output  1  one-cycle completion pulse to I-cache
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: same as the i_ signals, for the D-cache
- mem_read  output  1  registered read strobe to memory
- mem_write  output  1  registered write strobe to memory
- mem_addr  output  ADDR_W  registered block address
- mem_wdata  output  DATA_W  registered write block
- mem_rdata  input  DATA_W  memory read block, valid with mem_ready
- mem_ready  input  1  memory completion pulse
- grant  output  2  current owner: 2'b00 none, 2'b01 I, 2'b10 D

## Operation
- State machine: IDLE, BUSY, COOL. A `owner` register (I/D) and a `last` register record the most recently served requester.
- IDLE:
  - A requester is pending when its read|write is 1.
  - If only one side is pending, it is granted.
  - If both are pending, the side not equal to `last` is granted.
  - On the grant edge the arbiter loads mem_addr/mem_wdata from the winner. It sets mem_write=winner.write and sets mem_read=winner.read & ~winner.write, so a write wins if both are asserted. `owner` takes the winner and the state moves to BUSY.
- BUSY: mem_* outputs are held constant. The owner's request signals are no longer sampled, so a requester that drops its request mid-transaction does not abort it.
- Completion in BUSY: when mem_ready=1, the arbiter drives owner_ready=1 combinationally in that same cycle. On that edge it clears mem_read/mem_write, sets `last` to `owner`, and moves to COOL.
- COOL: lasts exactly one cycle and issues no grant. It masks the owner's request, which is still asserted that cycle because the caches deassert one cycle after ready. The state then returns to IDLE.
- Read data: i_rdata = d_rdata = mem_rdata at all times; only the ready strobe is steered.
- The non-owner's ready is always 0.
- mem_ready in IDLE or COOL is ignored.
- grant = 2'b00 in IDLE. In BUSY and COOL it is the owner encoding.
- Reset:
  - Asserting proc_reset at any time, including mid-BUSY, forces the state to IDLE and last=I.
  - All registered outputs clear: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, grant=0.
  - i_ready=d_ready=0.
  - Any in-flight transaction is discarded.

## Timing
- Request seen in IDLE at edge N, so mem_read/mem_write are 1 from N+1.
- If memory asserts mem_ready in cycle M, the owner sees ready in cycle M (zero added latency). mem strobes are 0 from M+1, COOL is cycle M+1, and IDLE is M+2.
- Back-to-back: the minimum gap between two memory strobes is 2 idle cycles (COOL plus IDLE arbitration).
- Fairness: with both sides continuously requesting, grants alternate D, I, D, I… The first tie after reset goes to D because last resets to I.
- mem outputs are registered only, with no combinational path from cache inputs to mem_*. The only combinational paths are mem_ready -> i_ready/d_ready and mem_rdata -> i_rdata/d_rdata.

## Test plan
- Single I read:
  - Stimulus: i_read=1, i_addr=28'h0000010; memory asserts ready 4 cycles after the strobe with rdata=128'hA5…A5.
  - Required: mem_read=1 and mem_addr=28'h0000010 one cycle after the request; i_ready=1 for exactly 1 cycle with i_rdata=A5…A5; d_ready stays 0; grant=01 through COOL, then 00.
- Simultaneous requests after reset: i_read=1 and d_write=1 with d_addr=28'h0000200, d_wdata=128'h1234.
  - Required: D is served first (mem_write=1, mem_addr=28'h0000200, mem_wdata=128'h1234).
  - Then 2 cycles with no strobe, then the I read is issued.
- Sustained contention: both sides re-request immediately for 6 transactions -> grant order D, I, D, I, D, I.
- D asserts read and write together -> mem_write=1, mem_read=0.
- proc_reset pulsed during BUSY -> all mem_* outputs and grant are 0 immediately (asynchronously).
  - Afterwards, a ready pulse from memory is ignored.
  - The next tie is granted to D.
- Spurious mem_ready=1 in IDLE with no request -> i_ready=d_ready=0 and the state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered memory port between the I-cache and D-cache,
// granting one transaction at a time with round-robin tie-breaking.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant
);
    typedef enum logic [1:0] {IDLE, BUSY, COOL} state_t;
    state_t state;
    logic owner, last;
    logic i_pend, d_pend, pick_d;
    always_comb begin
        i_pend = i_read | i_write;
        d_pend = d_read | d_write;
        // On a tie the side that was not served last wins
        pick_d = d_pend & (~i_pend | ~last);
    end
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_ready = (state == BUSY) & ~owner & mem_ready;
    assign d_ready = (state == BUSY) & owner & mem_ready;
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant     <= 2'b00;
        end else begin
            case (state)
                IDLE: if (i_pend | d_pend) begin
                    owner     <= pick_d;
                    mem_addr  <= pick_d ? d_addr : i_addr;
                    mem_wdata <= pick_d ? d_wdata : i_wdata;
                    mem_write <= pick_d ? d_write : i_write;
                    mem_read  <= pick_d ? d_read & ~d_write : i_read & ~i_write;
                    grant     <= pick_d ? 2'b10 : 2'b01;
                    state     <= BUSY;
                end
                BUSY: if (mem_ready) begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    last      <= owner;
                    state     <= COOL;
                end
                COOL: begin
                    grant <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
